// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the control decoder. It holds the PC and issues
//   instruction-memory requests with at most one request outstanding. Each
//   returned word goes into the IF/ID register. If IF/ID cannot take the word,
//   it waits in a 1-entry skid buffer instead. A redirect from branch resolve
//   flushes IF/ID and restarts fetch at the redirect target.
//
// Handshake (imem): o_imem_req is a valid that stays high until i_imem_ack.
//   o_imem_addr is stable while o_imem_req=1. i_imem_ack is a 1-cycle pulse
//   with i_imem_rdata valid in that same cycle. An ack seen while o_imem_req=0
//   is ignored.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   o_imem_req        request valid (FETCH or DROP)
//   o_imem_addr       request address (registered)
//   i_imem_ack        response strobe
//   i_imem_rdata      response instruction word
//   i_stall           downstream not accepting; IF/ID holds
//   i_redirect_valid  branch taken; flush and restart at i_redirect_pc
//   i_redirect_pc     redirect target
//   o_if_valid        IF/ID holds a live instruction
//   o_if_instr        IF/ID instruction
//   o_if_pc           address of o_if_instr
//   o_if_opcode       top 4 bits of o_if_instr (combinational)
//   o_dbg_state       current FSM state, for observation only
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_stall,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_if_valid,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic [ADDR_W-1:0]  o_if_pc,
    output logic [3:0]         o_if_opcode,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [ADDR_W-1:0]   r_next_pc;
    logic                r_if_valid;
    logic [INSTR_W-1:0]  r_if_instr;
    logic [ADDR_W-1:0]   r_if_pc;
    logic                r_skid_valid;
    logic [INSTR_W-1:0]  r_skid_instr;
    logic [ADDR_W-1:0]   r_skid_pc;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_req_addr_nxt;
    logic [ADDR_W-1:0]   w_next_pc_nxt;
    logic                w_accept;
    logic                w_ifid_load_mem;
    logic                w_ifid_load_skid;
    logic                w_skid_load;
    logic                w_skid_clear;

    // IF/ID can take a word this cycle if it is empty or being drained.
    assign w_accept = !r_if_valid || !i_stall;

    always_comb begin
        w_state_nxt      = r_state;
        w_req_addr_nxt   = r_req_addr;
        w_next_pc_nxt    = r_next_pc;
        w_ifid_load_mem  = 1'b0;
        w_ifid_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                if (i_redirect_valid) begin
                    w_req_addr_nxt = i_redirect_pc;
                end
            end
            ST_FETCH: begin
                if (i_imem_ack) begin
                    if (i_redirect_valid) begin
                        // The returning word belongs to the old path. Drop it.
                        w_req_addr_nxt = i_redirect_pc;
                    end else begin
                        w_req_addr_nxt = r_req_addr + ADDR_W'(1);
                        if (w_accept) begin
                            w_ifid_load_mem = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end else if (i_redirect_valid) begin
                    // The request is already in flight and cannot be retracted.
                    // Remember the target and squash the response when it comes.
                    w_next_pc_nxt = i_redirect_pc;
                    w_state_nxt   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_redirect_valid) begin
                    w_next_pc_nxt = i_redirect_pc;
                end
                if (i_imem_ack) begin
                    w_req_addr_nxt = i_redirect_valid ? i_redirect_pc : r_next_pc;
                    w_state_nxt    = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (i_redirect_valid) begin
                    w_skid_clear   = 1'b1;
                    w_req_addr_nxt = i_redirect_pc;
                    w_state_nxt    = ST_FETCH;
                end else if (!i_stall) begin
                    w_ifid_load_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                    w_state_nxt      = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_addr <= RESET_PC;
            r_next_pc  <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_next_pc  <= w_next_pc_nxt;
        end
    end

    // IF/ID: a redirect always flushes, even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (i_redirect_valid) begin
            r_if_valid <= 1'b0;
        end else if (w_ifid_load_mem) begin
            r_if_valid <= 1'b1;
            r_if_instr <= i_imem_rdata;
            r_if_pc    <= r_req_addr;
        end else if (w_ifid_load_skid) begin
            r_if_valid <= 1'b1;
            r_if_instr <= r_skid_instr;
            r_if_pc    <= r_skid_pc;
        end else if (!i_stall) begin
            r_if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (w_skid_clear) begin
            r_skid_valid <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= i_imem_rdata;
            r_skid_pc    <= r_req_addr;
        end
    end

    // The request is decoded from the state register, so an asynchronous
    // reset drops it immediately.
    assign o_imem_req  = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign o_imem_addr = r_req_addr;
    assign o_if_valid  = r_if_valid;
    assign o_if_instr  = r_if_instr;
    assign o_if_pc     = r_if_pc;
    assign o_if_opcode = r_if_instr[INSTR_W-1 -: 4];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DUT with RESET_PC = 0
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [7:0]  i_redirect_pc;
  logic        o_if_valid;
  logic [15:0] o_if_instr;
  logic [7:0]  o_if_pc;
  logic [3:0]  o_if_opcode;
  logic [1:0]  o_dbg_state;

  // DUT with RESET_PC = 0xFE, always acked, never stalled or redirected
  logic        o2_imem_req;
  logic [7:0]  o2_imem_addr;
  logic        i2_imem_ack;
  logic [15:0] i2_imem_rdata;
  logic        o2_if_valid;
  logic [15:0] o2_if_instr;
  logic [7:0]  o2_if_pc;
  logic [3:0]  o2_if_opcode;
  logic [1:0]  o2_dbg_state;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .i_stall          (i_stall),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_if_valid       (o_if_valid),
    .o_if_instr       (o_if_instr),
    .o_if_pc          (o_if_pc),
    .o_if_opcode      (o_if_opcode),
    .o_dbg_state      (o_dbg_state)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req       (o2_imem_req),
    .o_imem_addr      (o2_imem_addr),
    .i_imem_ack       (i2_imem_ack),
    .i_imem_rdata     (i2_imem_rdata),
    .i_stall          (1'b0),
    .i_redirect_valid (1'b0),
    .i_redirect_pc    (8'h00),
    .o_if_valid       (o2_if_valid),
    .o_if_instr       (o2_if_instr),
    .o_if_pc          (o2_if_pc),
    .o_if_opcode      (o2_if_opcode),
    .o_dbg_state      (o2_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents
  logic [15:0] mem [256];

  // Reference model. It tracks the fetch stream, not the FSM:
  //   m_started  - the first cycle after reset has passed
  //   m_addr     - address of the current or next request
  //   m_squash   - the outstanding request belongs to a flushed path
  //   m_resume   - where fetching continues after the squashed response
  //   skid_q     - parked words ({pc, instr}); while non-empty, no request
  //   m_ifv/m_pc/m_instr - the IF/ID contents
  bit          m_started;
  bit          m_squash;
  logic [7:0]  m_addr;
  logic [7:0]  m_resume;
  bit          m_ifv;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [23:0] skid_q[$];

  task automatic model_reset(input logic [7:0] rpc);
    m_started = 0;
    m_squash  = 0;
    m_addr    = rpc;
    m_resume  = rpc;
    m_ifv     = 0;
    m_pc      = '0;
    m_instr   = '0;
    skid_q.delete();
  endtask

  function automatic bit model_req();
    return m_started && (skid_q.size() == 0);
  endfunction

  task automatic model_step(input bit ack, input bit stall, input bit redir,
                            input logic [7:0] rpc);
    bit          accept;
    bit          loaded;
    logic [15:0] word;
    logic [23:0] ent;
    accept = !m_ifv || !stall;
    loaded = 0;
    word   = mem[m_addr];
    if (!m_started) begin
      m_started = 1;
      if (redir) m_addr = rpc;
    end else if (skid_q.size() != 0) begin
      if (redir) begin
        skid_q.delete();
        m_addr = rpc;
      end else if (!stall) begin
        ent     = skid_q.pop_front();
        m_pc    = ent[23:16];
        m_instr = ent[15:0];
        m_ifv   = 1;
        loaded  = 1;
      end
    end else if (m_squash) begin
      if (redir) m_resume = rpc;
      if (ack) begin
        m_addr   = m_resume;
        m_squash = 0;
      end
    end else if (ack) begin
      if (redir) begin
        m_addr = rpc;
      end else begin
        if (accept) begin
          m_ifv   = 1;
          m_pc    = m_addr;
          m_instr = word;
          loaded  = 1;
        end else begin
          skid_q.push_back({m_addr, word});
        end
        m_addr = m_addr + 8'd1;
      end
    end else if (redir) begin
      m_squash = 1;
      m_resume = rpc;
    end
    if (redir) m_ifv = 0;
    else if (!loaded && !stall) m_ifv = 0;
  endtask

  task automatic compare_all();
    check("imem_req", 32'(o_imem_req), 32'(model_req()));
    check("imem_addr", 32'(o_imem_addr), 32'(m_addr));
    check("if_valid", 32'(o_if_valid), 32'(m_ifv));
    if (m_ifv) begin
      check("if_instr", 32'(o_if_instr), 32'(m_instr));
      check("if_pc", 32'(o_if_pc), 32'(m_pc));
      check("if_opcode", 32'(o_if_opcode), 32'(m_instr[15:12]));
    end
  endtask

  // One clock: drive inputs now (just after a falling edge), advance the model
  // at the rising edge, compare at the next falling edge.
  task automatic step(input bit ack, input bit stall, input bit redir, input logic [7:0] rpc);
    bit a;
    a = ack && model_req();
    i_imem_ack       = a;
    i_imem_rdata     = a ? mem[o_imem_addr] : 16'($urandom);
    i_stall          = stall;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i2_imem_ack      = o2_imem_req;
    i2_imem_rdata    = 16'h1000 + {8'h00, o2_imem_addr};
    @(posedge clk);
    model_step(a, stall, redir, rpc);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [7:0] e8;
    rst_n            = 1'b0;
    i_imem_ack       = 1'b0;
    i_imem_rdata     = '0;
    i_stall          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i2_imem_ack      = 1'b0;
    i2_imem_rdata    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    model_reset(8'h00);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'h00);
    check("rst_valid", 32'(o_if_valid), 32'd0);
    check("rst_instr", 32'(o_if_instr), 32'd0);
    check("rst_pc", 32'(o_if_pc), 32'd0);
    check("rst2_req", 32'(o2_imem_req), 32'd0);
    check("rst2_addr", 32'(o2_imem_addr), 32'hFE);
    rst_n = 1'b1;

    // Streaming with an ack every cycle; the second instance checks wrap.
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0, 8'h00);
      check("d2_req", 32'(o2_imem_req), 32'd1);
      e8 = 8'hFE + 8'(k - 1);
      check("d2_addr", 32'(o2_imem_addr), 32'(e8));
      if (k >= 2) begin
        e8 = 8'hFE + 8'(k - 2);
        check("d2_valid", 32'(o2_if_valid), 32'd1);
        check("d2_pc", 32'(o2_if_pc), 32'(e8));
        check("d2_instr", 32'(o2_if_instr), 32'h1000 + 32'(e8));
      end
    end
    check("first_opcode", 32'(o_if_opcode), 32'h1);

    // Stall with a live word: the next word parks in the skid, no request in HOLD.
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    check("hold_req", 32'(o_imem_req), 32'd0);
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);

    // Redirect while a request to 0x05 is pending, ack two cycles later.
    step(1, 0, 1, 8'h05);
    step(0, 0, 1, 8'h40);
    check("drop_addr", 32'(o_imem_addr), 32'h05);
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("after_drop_addr", 32'(o_imem_addr), 32'h40);
    check("after_drop_valid", 32'(o_if_valid), 32'd0);
    repeat (3) step(1, 0, 0, 8'h00);

    // Redirect in the same cycle as the ack for 0x07.
    step(1, 0, 1, 8'h07);
    step(1, 0, 1, 8'h20);
    check("same_cycle_addr", 32'(o_imem_addr), 32'h20);
    repeat (3) step(1, 0, 0, 8'h00);

    // Randomised traffic over random memory contents
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)));
    end

    // Reset in the middle of a pending request to 0x09 with IF/ID live.
    step(1, 0, 1, 8'h08);
    step(1, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("pre_rst_addr", 32'(o_imem_addr), 32'h09);
    check("pre_rst_valid", 32'(o_if_valid), 32'd1);
    i_imem_ack = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(o_imem_req), 32'd0);
    check("mid_rst_valid", 32'(o_if_valid), 32'd0);
    check("mid_rst_addr", 32'(o_imem_addr), 32'h00);
    model_reset(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'h00);
    check("restart_addr", 32'(o_imem_addr), 32'h00);
    repeat (4) step(1, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
